shift_row: RTL and testbench
============================

Name: shift_row

Overview:
- Registered AES ShiftRows stage for the 128-bit AES datapath; it sits between SubBytes and MixColumns in the round pipeline.
- It permutes the 16 state bytes so that row r rotates left by r byte positions. It moves bytes only and performs no arithmetic.
- Result is captured into an output register when startTransition is sampled high. Parameter INVERSE selects InvShiftRows for the decrypt path.

Parameters:
- INVERSE, 0, 0 selects forward ShiftRows (row r rotates left by r); 1 selects InvShiftRows (row r rotates right by r).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- inputData  input  128  AES state in.
- startTransition  input  1  level-sensitive enable; while high, the permuted inputData is registered each cycle.
- outputData  output  128  registered permuted state.
- outputValid  output  1  high when outputData holds a result captured on the previous edge.

Behaviour:
- Byte mapping:
  - Byte k (k = 0..15) occupies bits [127-8k : 120-8k], so byte 0 is the MSB byte.
  - State is column-major: byte k is row r = k mod 4, column c = k div 4.
- Forward (INVERSE=0): out[r][c] = in[r][(c+r) mod 4].
- Inverse (INVERSE=1): out[r][c] = in[r][(c-r) mod 4].
- Row 0 is never moved in either mode.
- Permutation is pure wiring (combinational). The only state is the output register and the valid flag.
- Each rising edge, in priority order:
  - reset=1: outputData <= 0, outputValid <= 0. Reset overrides startTransition on the same edge.
  - else startTransition=1: outputData <= perm(inputData), outputValid <= 1.
  - else: outputData holds its last value, outputValid <= 0.
- Latency: 1 clock from sampling startTransition/inputData to the result appearing on outputData.
- Throughput: with startTransition held high, a new inputData is accepted every cycle. Changing inputData while enabled yields the new result one edge later.
- Holding startTransition high with constant inputData gives a stable outputData indefinitely; repeated captures do not re-apply the permutation.
- Reset mid-operation: the next edge clears both outputs. The first capture after reset deassertion occurs on the first edge where reset=0 and startTransition=1.
- Power-up before the first reset is undefined; the verifier checks only post-reset behaviour.
- No X propagation is introduced by the block itself. Every output bit is driven from the register.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with startTransition=1 and arbitrary inputData -> outputData=0, outputValid=0.
2. FIPS-197 vector, INVERSE=0:
   - inputData=63cab7040953d051cd60e0e7ba70e18c; hold startTransition=0 for 500 cycles, then hold it high for many thousands of cycles.
   - Required: outputData=6353e08c0960e104cd70b751bacad0e7 from the first edge after assertion onward, stable for the whole window.
   - Required: outputValid=1 throughout that window, and outputValid=0 (outputData=0) before assertion.
3. Byte-index vector, INVERSE=0: inputData=000102030405060708090a0b0c0d0e0f with startTransition=1 -> outputData=00050a0f04090e03080d02070c01060b after 1 cycle.
4. Inverse, INVERSE=1:
   - inputData=6353e08c0960e104cd70b751bacad0e7 -> 63cab7040953d051cd60e0e7ba70e18c.
   - Then 00050a0f04090e03080d02070c01060b -> 000102030405060708090a0b0c0d0e0f.
5. Enable/hold:
   - After capturing vector 3, drop startTransition and change inputData to all-ones -> outputData holds 00050a0f04090e03080d02070c01060b and outputValid=0.
   - Reassert startTransition -> outputData becomes all-ones after 1 cycle.
6. Back-to-back and reset:
   - Apply the vectors of scenarios 2 and 3 on consecutive cycles with startTransition=1 -> their results appear on consecutive cycles.
   - Assert reset concurrently with startTransition=1 -> outputData=0 on that edge.

Source files
------------

// File: rtl/shift_row.sv
// shift_row: registered AES ShiftRows (or InvShiftRows when INVERSE=1) with a one-cycle valid flag.
module shift_row #(
  parameter bit INVERSE = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] inputData,
  input  logic         startTransition,
  output logic [127:0] outputData,
  output logic         outputValid
);
  logic [127:0] permData;
  genvar k;
  // Byte k is row k%4, column k/4; byte 0 is the MSB byte.
  for (k = 0; k < 16; k++) begin : g_byte
    localparam int row = k % 4;
    localparam int col = k / 4;
    localparam int srcCol = INVERSE ? (col + 4 - row) % 4 : (col + row) % 4;
    localparam int src = row + 4 * srcCol;
    assign permData[127-8*k -: 8] = inputData[127-8*src -: 8];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      outputData  <= '0;
      outputValid <= 1'b0;
    end else begin
      if (startTransition) outputData <= permData;
      outputValid <= startTransition;
    end
  end
endmodule

// File: tb/tb_shift_row.sv
// tb_shift_row: scoreboard bench driving a forward and an inverse shift_row side by side.
module tb_shift_row;
  logic clock = 1'b0;
  logic reset, startTransition;
  logic [127:0] fwdIn, invIn, fwdOut, invOut;
  logic fwdValid, invValid;
  logic [127:0] fwdQ[$], invQ[$];
  int checks = 0;
  int errors = 0;
  localparam logic [127:0] FIPS_IN  = 128'h63cab7040953d051cd60e0e7ba70e18c;
  localparam logic [127:0] FIPS_OUT = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] IDX_IN   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IDX_OUT  = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] ONES     = {128{1'b1}};

  always #5 clock = ~clock;

  shift_row #(.INVERSE(1'b0)) dutFwd (
    .clock(clock), .reset(reset), .inputData(fwdIn),
    .startTransition(startTransition), .outputData(fwdOut), .outputValid(fwdValid)
  );
  shift_row #(.INVERSE(1'b1)) dutInv (
    .clock(clock), .reset(reset), .inputData(invIn),
    .startTransition(startTransition), .outputData(invOut), .outputValid(invValid)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Forward DUT gets fIn; inverse DUT gets the forward result and must undo it.
  task automatic issue(input logic [127:0] fIn, input logic [127:0] fExp);
    startTransition = 1'b1;
    fwdIn = fIn;
    invIn = fExp;
    fwdQ.push_back(fExp);
    invQ.push_back(fIn);
    cycle();
  endtask

  task automatic checkIdle(input string name, input logic [127:0] fExp, input logic [127:0] iExp);
    check({name, "_fwdData"}, fwdOut, fExp);
    check({name, "_fwdValid"}, {127'b0, fwdValid}, 128'b0);
    check({name, "_invData"}, invOut, iExp);
    check({name, "_invValid"}, {127'b0, invValid}, 128'b0);
  endtask

  always @(negedge clock) begin
    if (fwdValid === 1'b1) begin
      if (fwdQ.size() == 0) check("fwd_unexpected_valid", 128'b1, 128'b0);
      else check("fwd_scoreboard", fwdOut, fwdQ.pop_front());
    end
    if (invValid === 1'b1) begin
      if (invQ.size() == 0) check("inv_unexpected_valid", 128'b1, 128'b0);
      else check("inv_scoreboard", invOut, invQ.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    startTransition = 1'b1;
    fwdIn = 128'hdeadbeef_01234567_89abcdef_fedcba98;
    invIn = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    cycle();
    checkIdle("reset1", '0, '0);
    cycle();
    checkIdle("reset2", '0, '0);
    reset = 1'b0;
    startTransition = 1'b0;
    fwdIn = FIPS_IN;
    invIn = FIPS_OUT;
    repeat (3) cycle();
    checkIdle("preStart_early", '0, '0);
    repeat (497) cycle();
    checkIdle("preStart_late", '0, '0);
    repeat (2000) issue(FIPS_IN, FIPS_OUT);
    issue(IDX_IN, IDX_OUT);
    startTransition = 1'b0;
    fwdIn = ONES;
    invIn = ONES;
    cycle();
    checkIdle("hold", IDX_OUT, IDX_IN);
    cycle();
    checkIdle("hold2", IDX_OUT, IDX_IN);
    issue(ONES, ONES);
    issue(FIPS_IN, FIPS_OUT);
    issue(IDX_IN, IDX_OUT);
    issue(FIPS_IN, FIPS_OUT);
    reset = 1'b1;
    startTransition = 1'b1;
    fwdIn = IDX_IN;
    invIn = IDX_OUT;
    cycle();
    checkIdle("midReset", '0, '0);
    reset = 1'b0;
    startTransition = 1'b0;
    repeat (2) cycle();
    check("fwd_queue_drained", 128'(fwdQ.size()), 128'd0);
    check("inv_queue_drained", 128'(invQ.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
